// File: rtl/shift_load_ctrl.sv
// -----------------------------------------------------------------------------
// shift_load_ctrl
//
// Sequencing controller for a parallel-load shift register. Accepts a word over
// a valid/ready handshake, loads it into the register for one cycle, then
// shifts it left reg_size times while presenting the register MSB as a
// qualified serial stream (MSB first). Together with the register this forms a
// parallel-to-serial transmitter.
//
// Handshake: a word is transferred on every rising edge where word_valid and
// word_ready are both high. word_ready depends only on registered state, never
// on word_valid; the source must hold word_in stable while word_valid is high
// and not yet accepted.
//
// Optional feature macro: SHIFT_LOAD_CTRL_PIPE_EN
//   undefined : word_ready only in IDLE, one word per reg_size+2 cycles.
//   defined   : word_ready also in the last SHIFT cycle, so the next word can
//               go straight to LOAD; one word per reg_size+1 cycles.
//
// Parameters:
//   reg_size  - word width, must match the shift register (>= 2)
//   fill_bit  - constant driven on d_in, shifted into q[0]
//
// Ports:
//   clk        - clock, rising edge
//   clr        - asynchronous active-high reset (shared with the register)
//   word_in    - parallel word to transmit
//   word_valid - word_in is valid
//   word_ready - controller accepts word_in this cycle
//   q_msb      - register q[reg_size-1]
//   load, shl  - register control, never high together
//   x          - register parallel input, holds the captured word
//   d_in       - register serial input, tied to fill_bit
//   ser_out    - serial data, q_msb gated by ser_valid
//   ser_valid  - ser_out carries a data bit
//   done       - one-cycle pulse after the last bit of a word
//   state_dbg  - current FSM state (0 IDLE, 1 LOAD, 2 SHIFT)
// -----------------------------------------------------------------------------
module shift_load_ctrl #(
  parameter int   reg_size = 4,
  parameter logic fill_bit = 1'b0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [reg_size-1:0] word_in,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                q_msb,
  output logic                load,
  output logic                shl,
  output logic [reg_size-1:0] x,
  output logic                d_in,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = $clog2(reg_size);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [reg_size-1:0] x_hold;
  logic                accept;
  logic                last_shift;

  assign last_shift = (state == S_SHIFT) && (cnt == '0);
  assign accept     = word_valid && word_ready;

  // state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == '0) begin
`ifdef SHIFT_LOAD_CTRL_PIPE_EN
          state_nxt = accept ? S_LOAD : S_IDLE;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs, decoded from registered state only
  always_comb begin
    load       = 1'b0;
    shl        = 1'b0;
    ser_valid  = 1'b0;
    word_ready = 1'b0;
    case (state)
      S_IDLE:  word_ready = 1'b1;
      S_LOAD:  load       = 1'b1;
      S_SHIFT: begin
        shl       = 1'b1;
        ser_valid = 1'b1;
`ifdef SHIFT_LOAD_CTRL_PIPE_EN
        word_ready = last_shift;
`endif
      end
      default: ;
    endcase
  end

  // bit counter: loaded in LOAD, counts down through SHIFT, parks at 0
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (state == S_LOAD) begin
      cnt <= CNT_W'(reg_size - 1);
    end else if ((state == S_SHIFT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // captured word; changes only on an accepted handshake
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x_hold <= '0;
    end else if (accept) begin
      x_hold <= word_in;
    end
  end

  // done follows the last SHIFT cycle by one clock, even when the next word
  // has already moved the FSM into LOAD
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done <= 1'b0;
    end else begin
      done <= last_shift;
    end
  end

  assign x         = x_hold;
  assign d_in      = fill_bit;
  assign ser_out   = ser_valid & q_msb;
  assign state_dbg = state;

endmodule

// File: doc/shift_load_ctrl.md
# shift_load_ctrl

Sequencing controller that sits directly upstream of the parallel-load shift register and drives its `load`, `shl`, `x` and `d_in` inputs. It accepts a parallel word over a valid/ready handshake, loads it into the register in one cycle, then shifts it left for `reg_size` cycles, presenting the register's MSB as a qualified serial bit stream. Together with the register it forms a parallel-to-serial transmitter, MSB first.

## Interface
Parameters:
- `reg_size`, 4, word width; must equal the shift register's `reg_size`; legal range ≥ 2.
- `fill_bit`, 1'b0, constant driven on `d_in`; shifted into `q[0]` on every shift.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `clr`, input, 1, asynchronous, active-high reset. The same net also drives the shift register's `clr`.
- `word_in`, input, `reg_size`, parallel word to transmit.
- `word_valid`, input, 1, `word_in` is valid.
- `word_ready`, output, 1, the controller accepts `word_in` this cycle.
- `q_msb`, input, 1, shift register `q[reg_size-1]`.
- `load`, output, 1, to the register's `load`.
- `shl`, output, 1, to the register's `shl`.
- `x`, output, `reg_size`, to the register's `x`; holds the captured word.
- `d_in`, output, 1, to the register's `d_in`; tied to `fill_bit`.
- `ser_out`, output, 1, serial data; equals `q_msb` when `ser_valid` is high, otherwise 0.
- `ser_valid`, output, 1, `ser_out` carries a data bit this cycle.
- `done`, output, 1, one-cycle pulse after the last bit of a word.

## Operation
- States: IDLE, LOAD, SHIFT. State, the bit counter `cnt` (`$clog2(reg_size)` bits), `x_hold` and `done` are registers. `load`, `shl`, `ser_valid` and `word_ready` are decoded from the registered state only (Moore outputs).
- IDLE:
  - `word_ready`=1.
  - `word_valid`&&`word_ready` latches `word_in` into `x_hold` and moves to LOAD.
- LOAD:
  - `load`=1, `shl`=0, `x`=`x_hold`. The register captures the word at the end of this cycle.
  - Sets `cnt`=`reg_size`-1 and moves to SHIFT.
- SHIFT:
  - `shl`=1, `load`=0, `ser_valid`=1.
  - Decrements `cnt` every cycle. When `cnt`==0, moves to IDLE and sets `done`=1 for the next cycle.
- `load` and `shl` are never high together. Both are 0 in IDLE, so the register holds its value.
- Bit order: the first SHIFT cycle outputs `word[reg_size-1]`; bit k (counting from the MSB) appears in SHIFT cycle k.
- `word_in` changes outside an accepted handshake are ignored. `x` holds its last value between words.

## Timing
- Reset values while `clr` is high, and on release:
  - state=IDLE, `cnt`=0, `x_hold`/`x`=0.
  - `load`=0, `shl`=0, `ser_valid`=0, `ser_out`=0, `done`=0.
  - `word_ready`=1, `d_in`=`fill_bit`.
- Latency: handshake in cycle N → `load` in N+1 → first `ser_valid` in N+2 → last bit in N+1+`reg_size` → `done` in N+2+`reg_size`.
- Throughput without `SHIFT_LOAD_CTRL_PIPE_EN`: one word per `reg_size`+2 cycles.
- `clr` asserted mid-SHIFT or mid-LOAD: the word is abandoned immediately, no `done` pulse, and the next word starts from IDLE after release.
- A handshake in the same cycle as `clr` is discarded.

## Configuration
- `SHIFT_LOAD_CTRL_PIPE_EN` undefined:
  - `word_ready` is high only in IDLE.
  - At least one IDLE cycle separates words.
- `SHIFT_LOAD_CTRL_PIPE_EN` defined:
  - `word_ready` is also high in the last SHIFT cycle (`cnt`==0).
  - An accepted word there goes directly to LOAD; `done` still pulses in that LOAD cycle.
  - Sustained throughput: one word per `reg_size`+1 cycles.
  - Behaviour in all other states is identical to the undefined case.

## Test plan
All scenarios use `reg_size`=4.
- Reset: assert `clr` asynchronously between edges → all outputs reach their reset values without a clock edge; `word_ready`=1.
- Single word: `word_in`=4'b1011 with `fill_bit`=0 → `load` pulses one cycle; `ser_out`=1,0,1,1 with `ser_valid` high for exactly 4 cycles; `done` pulses in the next cycle; register `q`=4'b0000 afterwards.
- Fill bit: `fill_bit`=1, `word_in`=4'b0000 → `ser_out`=0,0,0,0; register `q`=4'b1111 after SHIFT.
- Back-pressure: hold `word_valid` high with a second word 4'b0110 during SHIFT → not accepted until `word_ready`. Second `load` occurs 6 cycles after the first without the macro, and 5 cycles after with the macro.
- Abort: assert `clr` in the 2nd SHIFT cycle → `shl` and `ser_valid` drop immediately, no `done`; the next word 4'b1000 then serialises cleanly as 1,0,0,0.
- Invariant check over random valid traffic → `load`&&`shl` is never 1; `ser_valid` count equals 4 × `done` count.
